// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// One master's command channel into the memory bus arbiter.
//
// Signals:
//   req      master -> arbiter  command request, held with payload until gnt
//   addr     master -> arbiter  word address (ADDR_W bits)
//   write    master -> arbiter  1 = write, 0 = read
//   data_w   master -> arbiter  write data
//   mask_w   master -> arbiter  byte-lane write enables
//   gnt      arbiter -> master  command accepted this cycle (combinational)
//   rvalid   arbiter -> master  read data valid this cycle (registered)
//   data_r   arbiter -> master  read data, qualified by rvalid
//
// Modports: master (the requester side), slave (the arbiter side).
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 30
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [31:0]       data_w;
    logic [3:0]        mask_w;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       data_r;

    modport master (
        output req, addr, write, data_w, mask_w,
        input  gnt, rvalid, data_r
    );

    modport slave (
        input  req, addr, write, data_w, mask_w,
        output gnt, rvalid, data_r
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port synchronous word-addressed RAM between two masters
// (m0 = CPU core, m1 = DMA / debug loader). At most one command is accepted
// per cycle and registered onto the RAM port; read data returns two cycles
// after acceptance with an rvalid strobe routed to the issuing master.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   m0, m1      slave modports of mem_bus_arbiter_if (command channels)
//   mem_en      out  RAM command valid
//   mem_addr    out  RAM word address
//   mem_write   out  RAM write strobe
//   mem_data_w  out  RAM write data
//   mem_mask_w  out  RAM byte-lane mask
//   mem_data_r  in   RAM read data, valid one cycle after the command
//
// Configuration macro:
//   MEM_BUS_ARBITER_ROUND_ROBIN_EN  defined   -> round-robin under contention
//                                   undefined -> fixed priority, m0 wins
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W = 30
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [31:0]       mem_data_w,
    output logic [3:0]        mem_mask_w,
    input  logic [31:0]       mem_data_r
);

    logic last;      // most recently granted master
    logic owner;     // master owning the command currently on the RAM port
    logic rd_owner;  // master owning the read data returning this cycle
    logic rd_pend;   // a read's data is on mem_data_r this cycle
    logic pick_m0;   // contention winner: 1 = m0, 0 = m1
    logic gnt0;
    logic gnt1;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        pick_m0 = 1'b1;
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
        // last == 1 means m1 went last, so it is m0's turn.
        pick_m0 = last;
`else
        // Fixed priority: last is tracked but never changes the decision.
        pick_m0 = 1'b1 | last;
`endif
        // Qualifying with reset keeps grants low while the block is held.
        gnt0 = reset & m0.req & (~m1.req |  pick_m0);
        gnt1 = reset & m1.req & (~m0.req | ~pick_m0);
    end

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_en     <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_data_w <= '0;
            mem_mask_w <= '0;
            owner      <= 1'b0;
            rd_owner   <= 1'b0;
            rd_pend    <= 1'b0;
            last       <= 1'b1;  // so m0 wins the first contention
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples pre-edge values (rd_pend sees the old
            // mem_en/mem_write, not the ones loaded in this same block).
            rd_pend  <= mem_en & ~mem_write;
            rd_owner <= owner;
            if (gnt0 | gnt1) begin
                mem_en     <= 1'b1;
                owner      <= gnt1;
                last       <= gnt1;
                mem_addr   <= gnt1 ? m1.addr   : m0.addr;
                mem_write  <= gnt1 ? m1.write  : m0.write;
                mem_data_w <= gnt1 ? m1.data_w : m0.data_w;
                mem_mask_w <= gnt1 ? m1.mask_w : m0.mask_w;
            end else begin
                // Payload holds; only the strobes drop.
                mem_en    <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

    assign m0.rvalid = rd_pend & ~rd_owner;
    assign m1.rvalid = rd_pend &  rd_owner;

    // Data is shared; masters qualify it with their own rvalid.
    assign m0.data_r = mem_data_r;
    assign m1.data_r = mem_data_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed-vector bench for mem_bus_arbiter with a scoreboard: each accepted
// read pushes its expected {master, data} into a queue, and an independent
// monitor pops and compares whenever either master sees rvalid. A small
// sequential RAM model sits on the memory port.
// Builds for either setting of MEM_BUS_ARBITER_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 30;

    localparam logic [31:0] D10 = 32'hDEAD_BEEF;
    localparam logic [31:0] D20 = 32'hAAAA_AAAA;
    localparam logic [31:0] D20_NEW = 32'hAAAA_5678;
    localparam logic [31:0] D40 = 32'h4040_4040;
    localparam logic [31:0] D50 = 32'h5050_5050;
    localparam logic [31:0] D60 = 32'h6060_6060;

    logic              clock;
    logic              reset;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [31:0]       mem_data_w;
    logic [3:0]        mem_mask_w;
    logic [31:0]       mem_data_r;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) m0 ();
    mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) m1 ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .m0         (m0.slave),
        .m1         (m1.slave),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_data_w (mem_data_w),
        .mem_mask_w (mem_mask_w),
        .mem_data_r (mem_data_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sequential single-port RAM: command in cycle N+1, data out in N+2.
    logic [31:0] ram [256];

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask_w[b])
                        ram[mem_addr[7:0]][8*b +: 8] <= mem_data_w[8*b +: 8];
            end else begin
                mem_data_r <= ram[mem_addr[7:0]];
            end
        end
    end

    int passed = 0;
    int total  = 0;
    logic [32:0] sb [$];  // {master index, expected data}

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic set_m0(input bit req, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] mk);
        m0.req = req; m0.write = wr; m0.addr = a; m0.data_w = d; m0.mask_w = mk;
    endtask

    task automatic set_m1(input bit req, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [3:0] mk);
        m1.req = req; m1.write = wr; m1.addr = a; m1.data_w = d; m1.mask_w = mk;
    endtask

    // One cycle: inputs already driven at posedge+1. Checks the grants at
    // the falling edge, records expected read data for granted reads, and
    // returns 1 time unit after the next rising edge.
    task automatic step(input bit eg0, input bit eg1,
                        input logic [31:0] ed0, input logic [31:0] ed1);
        @(negedge clock);
        check("m0_gnt", m0.gnt, eg0);
        check("m1_gnt", m1.gnt, eg1);
        if (eg0 && !m0.write) sb.push_back({1'b0, ed0});
        if (eg1 && !m1.write) sb.push_back({1'b1, ed1});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: compares every returning read against the scoreboard.
    always @(negedge clock) begin
        if (m0.rvalid || m1.rvalid) begin
            check("rvalid_onehot", m0.rvalid & m1.rvalid, 1'b0);
            if (sb.size() == 0) begin
                check("rvalid_unexpected", {m1.rvalid, m0.rvalid}, 2'b00);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("rvalid_owner", m1.rvalid, e[32]);
                check("rvalid_data", m1.rvalid ? m1.data_r : m0.data_r, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0100_0000 + i;
        ram[8'h10] = D10;
        ram[8'h20] = D20;
        ram[8'h40] = D40;
        ram[8'h50] = D50;
        ram[8'h60] = D60;
        mem_data_r = '0;

        // Reset state; m0 requesting while reset is low must not be granted.
        reset = 1'b0;
        set_m0(1'b1, 1'b0, 'h10, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        @(negedge clock);
        check("rst_m0_gnt", m0.gnt, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_data_w", mem_data_w, '0);
        check("rst_mem_mask_w", mem_mask_w, '0);
        check("rst_rvalid", {m1.rvalid, m0.rvalid}, 2'b00);
        @(posedge clock);
        #1;
        set_m0(1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        idle(1);

        // m0 read of 0x10: grant N, RAM port N+1, rvalid N+2.
        set_m0(1'b1, 1'b0, 'h10, '0, '0);
        step(1'b1, 1'b0, D10, '0);
        check("rd_mem_en", mem_en, 1'b1);
        check("rd_mem_addr", mem_addr, 'h10);
        check("rd_mem_write", mem_write, 1'b0);
        set_m0(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        check("rd_m0_rvalid", m0.rvalid, 1'b1);
        check("rd_m1_rvalid", m1.rvalid, 1'b0);
        check("idle_mem_en", mem_en, 1'b0);
        idle(1);

        // m1 masked write to 0x20, then read-back the following cycle.
        set_m1(1'b1, 1'b1, 'h20, 32'h1234_5678, 4'b0011);
        step(1'b0, 1'b1, '0, '0);
        check("wr_mem_write", mem_write, 1'b1);
        check("wr_mem_data_w", mem_data_w, 32'h1234_5678);
        check("wr_mem_mask_w", mem_mask_w, 4'b0011);
        set_m1(1'b1, 1'b0, 'h20, '0, '0);
        step(1'b0, 1'b1, '0, D20_NEW);
        check("wr_strobe_drop", mem_write, 1'b0);
        check("wr_no_rvalid", m1.rvalid, 1'b0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        idle(3);

        // Continuous contention for 4 cycles.
        set_m0(1'b1, 1'b0, 'h40, '0, '0);
        set_m1(1'b1, 1'b0, 'h50, '0, '0);
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
        step(1'b1, 1'b0, D40, '0);
        step(1'b0, 1'b1, '0, D50);
        step(1'b1, 1'b0, D40, '0);
        step(1'b0, 1'b1, '0, D50);
`else
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, D40, '0);
`endif
        set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        idle(3);

        // Reset in the cycle after a read is accepted: the read is dropped.
        set_m0(1'b1, 1'b0, 'h10, '0, '0);
        step(1'b1, 1'b0, D10, '0);
        void'(sb.pop_back());  // this read is killed by the reset below
        set_m0(1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        #1;
        check("arst_mem_en", mem_en, 1'b0);
        check("arst_rd_pend", dut.rd_pend, 1'b0);
        check("arst_m0_rvalid", m0.rvalid, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        check("arst_n2_m0_rvalid", m0.rvalid, 1'b0);
        check("arst_n2_mem_en", mem_en, 1'b0);
        set_m0(1'b1, 1'b0, 'h40, '0, '0);
        set_m1(1'b1, 1'b0, 'h50, '0, '0);
        step(1'b1, 1'b0, D40, '0);
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
        step(1'b0, 1'b1, '0, D50);
`else
        step(1'b1, 1'b0, D40, '0);
        set_m0(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, '0, D50);
`endif
        set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        idle(3);

        // m0 streaming alone, then m1 joins mid-stream.
        set_m0(1'b1, 1'b0, 'h60, '0, '0);
        step(1'b1, 1'b0, D60, '0);
        set_m1(1'b1, 1'b0, 'h50, '0, '0);
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
        step(1'b0, 1'b1, '0, D50);
        check("join_m1_addr", mem_addr, 'h50);
        step(1'b1, 1'b0, D60, '0);
        check("join_m0_payload", mem_addr, 'h60);
`else
        step(1'b1, 1'b0, D60, '0);
        step(1'b1, 1'b0, D60, '0);
        check("join_m0_payload", mem_addr, 'h60);
`endif
        set_m0(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, '0, D50);
        check("join_m1_late_addr", mem_addr, 'h50);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        idle(4);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
